farm_request_ctrl: RTL

- Upstream conditioner for the farm-road traffic light controller. It produces that controller's car-present input `c` from a raw vehicle loop detector and a pedestrian push-button.
- Synchronises and debounces both raw inputs, and latches pedestrian requests until the farm road has been served.
- Watches the controller's FG/FY lamp outputs to track service.
- Enforces a hold-off after each farm phase so the main roads cannot be starved.

---
 rtl/farm_request_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/farm_request_ctrl.sv
// farm_request_ctrl
// Builds the farm-road request `c` for the traffic light controller from a
// raw loop detector and a pedestrian button. Both raw inputs are
// synchronised and debounced. Pedestrian presses are latched until the farm
// road has been served. After every farm phase a hold-off window keeps `c`
// low so the main road cannot be starved.

module farm_request_ctrl #(
  parameter int DEB_CYC     = 4,   // identical samples needed to flip a debounced level
  parameter int HOLDOFF_CYC = 40,  // cycles `c` is held low after a farm phase
  parameter int WAIT_W      = 8    // width of the saturating wait counter
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              det_raw,
  input  logic              ped_raw,
  input  logic              FG,
  input  logic              FY,
  output logic              c,
  output logic              ped_wait,
  output logic [WAIT_W-1:0] wait_cnt,
  output logic              holdoff
);

  localparam int DEB_W  = $clog2(DEB_CYC + 1);
  localparam int HOLD_W = $clog2(HOLDOFF_CYC + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_SERVE   = 2'd2;
  localparam logic [1:0] S_HOLDOFF = 2'd3;

  // Registered state
  logic              det_s1, det_s2, ped_s1, ped_s2;
  logic              det_deb, ped_deb;
  logic [DEB_W-1:0]  det_cnt, ped_cnt;
  logic              ped_req;
  logic [1:0]        state;
  logic [HOLD_W-1:0] hold_cnt;

  // Next-state values
  logic              det_deb_n, ped_deb_n;
  logic [DEB_W-1:0]  det_cnt_n, ped_cnt_n;
  logic              ped_req_n;
  logic [1:0]        state_n;
  logic [HOLD_W-1:0] hold_cnt_n;
  logic [WAIT_W-1:0] wait_cnt_n;
  logic              c_n, holdoff_n;

  logic req, req_n, ped_rise, service_done;

  // Debounce both synchronised inputs: a level flips only after DEB_CYC
  // consecutive disagreeing samples; any agreeing sample restarts the count.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    det_deb_n = det_deb;
    det_cnt_n = '0;
    ped_deb_n = ped_deb;
    ped_cnt_n = '0;
    if (det_s2 != det_deb) begin
      if (det_cnt == DEB_W'(DEB_CYC - 1)) det_deb_n = ~det_deb;
      else                                det_cnt_n = det_cnt + 1'b1;
    end
    if (ped_s2 != ped_deb) begin
      if (ped_cnt == DEB_W'(DEB_CYC - 1)) ped_deb_n = ~ped_deb;
      else                                ped_cnt_n = ped_cnt + 1'b1;
    end
  end

  assign req      = det_deb | ped_req;
  assign ped_rise = ped_deb_n & ~ped_deb;

  // Service FSM; a yellow seen outside SERVE means green was missed and the
  // phase is still treated as served.
  always_comb begin
    state_n    = state;
    hold_cnt_n = hold_cnt;
    case (state)
      S_IDLE: begin
        if (FY)       state_n = S_HOLDOFF;
        else if (req) state_n = S_REQ;
      end
      S_REQ: begin
        if (FG)        state_n = S_SERVE;
        else if (FY)   state_n = S_HOLDOFF;
        else if (!req) state_n = S_IDLE;
      end
      S_SERVE: begin
        if (FY) state_n = S_HOLDOFF;
      end
      S_HOLDOFF: begin
        if (hold_cnt == HOLD_W'(HOLDOFF_CYC)) begin
          state_n    = S_IDLE;
          hold_cnt_n = '0;
        end else begin
          hold_cnt_n = hold_cnt + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
    // The hold-off counter starts at 1 on entry so it runs 1..HOLDOFF_CYC.
    if (state_n == S_HOLDOFF && state != S_HOLDOFF) hold_cnt_n = HOLD_W'(1);
  end

  assign service_done = (state_n == S_HOLDOFF) && (state != S_HOLDOFF);

  // Pedestrian latch (a new press beats a simultaneous clear), wait counter
  // and output decode, all evaluated on next-state so outputs are registered.
  always_comb begin
    if (ped_rise)          ped_req_n = 1'b1;
    else if (service_done) ped_req_n = 1'b0;
    else                   ped_req_n = ped_req;

    req_n = det_deb_n | ped_req_n;

    wait_cnt_n = wait_cnt;
    case (state_n)
      S_IDLE:  wait_cnt_n = '0;
      S_REQ:   begin
        if (state != S_REQ)        wait_cnt_n = '0;
        else if (wait_cnt != '1)   wait_cnt_n = wait_cnt + 1'b1;
      end
      S_SERVE: if (state != S_SERVE) wait_cnt_n = '0;
      default: wait_cnt_n = wait_cnt;
    endcase

    c_n       = (state_n == S_REQ) || ((state_n == S_SERVE) && req_n);
    holdoff_n = (state_n == S_HOLDOFF);
  end

  // All state and registered outputs; everything clears as soon as rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      det_s1   <= 1'b0;
      det_s2   <= 1'b0;
      ped_s1   <= 1'b0;
      ped_s2   <= 1'b0;
      det_deb  <= 1'b0;
      ped_deb  <= 1'b0;
      det_cnt  <= '0;
      ped_cnt  <= '0;
      ped_req  <= 1'b0;
      state    <= S_IDLE;
      hold_cnt <= '0;
      wait_cnt <= '0;
      c        <= 1'b0;
      holdoff  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values,
      // which is what makes the two-flop synchroniser chain work.
      det_s1   <= det_raw;
      det_s2   <= det_s1;
      ped_s1   <= ped_raw;
      ped_s2   <= ped_s1;
      det_deb  <= det_deb_n;
      ped_deb  <= ped_deb_n;
      det_cnt  <= det_cnt_n;
      ped_cnt  <= ped_cnt_n;
      ped_req  <= ped_req_n;
      state    <= state_n;
      hold_cnt <= hold_cnt_n;
      wait_cnt <= wait_cnt_n;
      c        <= c_n;
      holdoff  <= holdoff_n;
    end
  end

  assign ped_wait = ped_req;

endmodule
